// File: rtl/alu_bist_pkg.sv
// Shared definitions for the ALU BIST scheduler: FSM states, ALU control
// codes, the six-entry self-test op table and the LFSR feedback polynomial.
package alu_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_FAULT
  } state_e;

  localparam logic [2:0] CONT_AND = 3'b000;
  localparam logic [2:0] CONT_OR  = 3'b001;
  localparam logic [2:0] CONT_ADD = 3'b010;
  localparam logic [2:0] CONT_SUB = 3'b110;
  localparam logic [2:0] CONT_SLT = 3'b111;

  localparam int          NUM_OPS   = 6;
  localparam logic [31:0] LFSR_POLY = 32'h80200003;

  // Entry 5 repeats SUB; the top feeds it equal operands so the zero flag is exercised.
  function automatic logic [2:0] opCont(input logic [2:0] idx);
    case (idx)
      3'd0:    return CONT_AND;
      3'd1:    return CONT_OR;
      3'd2:    return CONT_ADD;
      3'd4:    return CONT_SLT;
      default: return CONT_SUB;
    endcase
  endfunction

  function automatic logic [31:0] lfsrStep(input logic [31:0] v);
    return {1'b0, v[31:1]} ^ (v[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/alu_golden.sv
// Combinational reference ALU used to judge every injected BIST vector.
module alu_golden (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [2:0]  i_cont,
  output logic [31:0] o_result,
  output logic        o_zero
);

  logic [31:0] w_bb;
  logic [31:0] w_sum;

  assign w_bb  = i_cont[2] ? ~i_b : i_b;
  assign w_sum = i_a + w_bb + {31'b0, i_cont[2]};

  // SLT takes the raw sign of the difference, deliberately without overflow correction.
  always_comb begin
    o_result = w_sum;
    case (i_cont[1:0])
      2'b00:   o_result = i_a & w_bb;
      2'b01:   o_result = i_a | w_bb;
      2'b10:   o_result = w_sum;
      default: o_result = {31'b0, w_sum[31]};
    endcase
  end

  assign o_zero = (o_result == 32'h0);

endmodule

// File: rtl/alu_bist_sched.sv
// Shares the datapath ALU between core traffic and an opportunistic BIST
// engine that injects LFSR vectors on idle cycles and checks the results.
module alu_bist_sched
  import alu_bist_pkg::*;
#(
  parameter int          PERIOD    = 16,
  parameter int          ERR_LIMIT = 3,
  parameter logic [31:0] LFSR_SEED = 32'hACE11234
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_bist_en,
  input  logic        i_clr_err,
  input  logic        i_core_valid,
  input  logic [31:0] i_core_a,
  input  logic [31:0] i_core_b,
  input  logic [2:0]  i_core_cont,
  output logic [31:0] o_alu_a,
  output logic [31:0] o_alu_b,
  output logic [2:0]  o_alu_cont,
  input  logic [31:0] i_alu_result,
  input  logic        i_alu_zero,
  output logic        o_bist_active,
  output logic [15:0] o_tests_done,
  output logic [7:0]  o_err_cnt,
  output logic        o_fault,
  output logic [31:0] o_fail_a,
  output logic [31:0] o_fail_b,
  output logic [2:0]  o_fail_cont
);

  localparam int            CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(PERIOD - 1);
  localparam logic [7:0]    LIMIT  = 8'(ERR_LIMIT);

  state_e        r_state;
  state_e        w_nextState;
  logic [CW-1:0] r_periodCnt;
  logic [31:0]   r_lfsr;
  logic [2:0]    r_opIdx;
  logic [15:0]   r_testsDone;
  logic [7:0]    r_errCnt;
  logic          r_capValid;
  logic [31:0]   r_failA;
  logic [31:0]   r_failB;
  logic [2:0]    r_failCont;

  logic          w_bistActive;
  logic [31:0]   w_vecA;
  logic [31:0]   w_vecB;
  logic [2:0]    w_vecCont;
  logic [31:0]   w_goldResult;
  logic          w_goldZero;
  logic          w_mismatch;
  logic [7:0]    w_errInc;
  logic          w_limitHit;

  // Core traffic always wins; a BIST vector only rides on a cycle the core leaves idle.
  assign w_bistActive = (r_state == ST_ARMED) & ~i_core_valid & i_bist_en;
  assign w_vecA       = r_lfsr;
  assign w_vecB       = (r_opIdx == 3'd5) ? r_lfsr : {r_lfsr[15:0], r_lfsr[31:16]};
  assign w_vecCont    = opCont(r_opIdx);

  assign o_alu_a       = w_bistActive ? w_vecA    : i_core_a;
  assign o_alu_b       = w_bistActive ? w_vecB    : i_core_b;
  assign o_alu_cont    = w_bistActive ? w_vecCont : i_core_cont;
  assign o_bist_active = w_bistActive;

  alu_golden u_golden (
    .i_a      (w_vecA),
    .i_b      (w_vecB),
    .i_cont   (w_vecCont),
    .o_result (w_goldResult),
    .o_zero   (w_goldZero)
  );

  assign w_mismatch = w_bistActive &
                      ((i_alu_result != w_goldResult) | (i_alu_zero != w_goldZero));
  assign w_errInc   = (r_errCnt == 8'hFF) ? 8'hFF : r_errCnt + 8'd1;
  assign w_limitHit = (w_errInc >= LIMIT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_nextState;
  end

  // A clear on the same edge as a limit-reaching mismatch keeps the block out of FAULT.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:  if (i_bist_en && (r_periodCnt == '0)) w_nextState = ST_ARMED;
      ST_ARMED: begin
        if (!i_bist_en)        w_nextState = ST_IDLE;
        else if (w_bistActive) w_nextState = (w_mismatch && w_limitHit && !i_clr_err) ?
                                             ST_FAULT : ST_IDLE;
      end
      ST_FAULT: if (i_clr_err) w_nextState = ST_IDLE;
      default:  w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_periodCnt <= RELOAD;
    end else if (r_state == ST_IDLE) begin
      if (!i_bist_en || (r_periodCnt == '0)) r_periodCnt <= RELOAD;
      else                                   r_periodCnt <= r_periodCnt - 1'b1;
    end else if ((r_state == ST_FAULT) && i_clr_err) begin
      r_periodCnt <= RELOAD;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lfsr      <= LFSR_SEED;
      r_opIdx     <= 3'd0;
      r_testsDone <= 16'd0;
    end else if (w_bistActive) begin
      r_lfsr      <= lfsrStep(r_lfsr);
      r_opIdx     <= (r_opIdx == 3'(NUM_OPS - 1)) ? 3'd0 : r_opIdx + 3'd1;
      r_testsDone <= r_testsDone + 16'd1;
    end
  end

  // fail_* survive a clear so the last logged vector stays visible until a new capture.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_errCnt   <= 8'd0;
      r_capValid <= 1'b0;
      r_failA    <= 32'h0;
      r_failB    <= 32'h0;
      r_failCont <= 3'd0;
    end else begin
      if (i_clr_err) begin
        r_errCnt   <= 8'd0;
        r_capValid <= 1'b0;
      end else if (w_mismatch) begin
        r_errCnt   <= w_errInc;
        r_capValid <= 1'b1;
      end
      if (w_mismatch && !r_capValid) begin
        r_failA    <= w_vecA;
        r_failB    <= w_vecB;
        r_failCont <= w_vecCont;
      end
    end
  end

  assign o_tests_done = r_testsDone;
  assign o_err_cnt    = r_errCnt;
  assign o_fault      = (r_state == ST_FAULT);
  assign o_fail_a     = r_failA;
  assign o_fail_b     = r_failB;
  assign o_fail_cont  = r_failCont;

endmodule

// File: tb/tb_alu_bist_sched.sv
// Bench for alu_bist_sched: a cycle-level reference of the scheduling rules
// checked every cycle, plus directed scenarios with hand-computed values.
module tb_alu_bist_sched;

  localparam int PERIOD    = 4;
  localparam int ERR_LIMIT = 2;

  logic        clk = 1'b0;
  logic        rstN;
  logic        bistEn;
  logic        clrErr;
  logic        coreValid;
  logic [31:0] coreA;
  logic [31:0] coreB;
  logic [2:0]  coreCont;
  logic [31:0] aluA;
  logic [31:0] aluB;
  logic [2:0]  aluCont;
  logic [31:0] aluResult;
  logic        aluZero;
  logic        bistActive;
  logic [15:0] testsDone;
  logic [7:0]  errCnt;
  logic        fault;
  logic [31:0] failA;
  logic [31:0] failB;
  logic [2:0]  failCont;
  logic        inject;
  logic        chkEn;

  int passCnt  = 0;
  int totalCnt = 0;

  alu_bist_sched #(
    .PERIOD    (PERIOD),
    .ERR_LIMIT (ERR_LIMIT),
    .LFSR_SEED (32'hACE11234)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .i_bist_en    (bistEn),
    .i_clr_err    (clrErr),
    .i_core_valid (coreValid),
    .i_core_a     (coreA),
    .i_core_b     (coreB),
    .i_core_cont  (coreCont),
    .o_alu_a      (aluA),
    .o_alu_b      (aluB),
    .o_alu_cont   (aluCont),
    .i_alu_result (aluResult),
    .i_alu_zero   (aluZero),
    .o_bist_active(bistActive),
    .o_tests_done (testsDone),
    .o_err_cnt    (errCnt),
    .o_fault      (fault),
    .o_fail_a     (failA),
    .o_fail_b     (failB),
    .o_fail_cont  (failCont)
  );

  always #5 clk = ~clk;

  // Plain arithmetic view of what a correct ALU returns for each control code.
  function automatic logic [31:0] refResult(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] c);
    logic [31:0] diff;
    diff = a - b;
    case (c)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return diff;
      3'b111:  return {31'b0, diff[31]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] lfsrNext(input logic [31:0] x);
    if (x[0]) return (x >> 1) ^ 32'h80200003;
    return x >> 1;
  endfunction

  // External ALU: healthy, except bit 0 of the result is flipped on BIST cycles when inject is set.
  always_comb begin
    logic [31:0] res;
    res       = refResult(aluA, aluB, aluCont);
    aluZero   = (res == 32'h0);
    aluResult = res ^ {31'b0, inject & bistActive};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  // Reference model: mode 0 waiting, 1 armed, 2 faulted.
  logic [2:0]  opTab [6] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b110};
  int          mMode     = 0;
  int          mIdleLeft = PERIOD - 1;
  logic [31:0] mLfsr     = 32'hACE11234;
  int          mOp       = 0;
  int          mTests    = 0;
  int          mErr      = 0;
  bit          mCapValid = 1'b0;
  logic [31:0] mFailA    = 32'h0;
  logic [31:0] mFailB    = 32'h0;
  logic [2:0]  mFailCont = 3'd0;

  function automatic logic [31:0] modelVecB();
    return (mOp == 5) ? mLfsr : {mLfsr[15:0], mLfsr[31:16]};
  endfunction

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mMode = 0; mIdleLeft = PERIOD - 1; mLfsr = 32'hACE11234; mOp = 0;
      mTests = 0; mErr = 0; mCapValid = 1'b0;
      mFailA = 32'h0; mFailB = 32'h0; mFailCont = 3'd0;
    end else begin
      bit          act;
      bit          mis;
      logic [31:0] vb;
      logic [31:0] gold;
      act  = (mMode == 1) && bistEn && !coreValid;
      vb   = modelVecB();
      gold = refResult(mLfsr, vb, opTab[mOp]);
      mis  = act && ((aluResult != gold) || (aluZero != (gold == 32'h0)));
      if (mMode == 2) begin
        if (clrErr) begin
          mMode = 0; mIdleLeft = PERIOD - 1; mErr = 0; mCapValid = 1'b0;
        end
      end else begin
        if (act) begin
          if (mis) begin
            if (!mCapValid) begin
              mFailA = mLfsr; mFailB = vb; mFailCont = opTab[mOp];
            end
            mCapValid = 1'b1;
            mErr = (mErr < 255) ? mErr + 1 : 255;
          end
          mMode  = (mis && !clrErr && mErr >= ERR_LIMIT) ? 2 : 0;
          mTests = (mTests + 1) % 65536;
          mLfsr  = lfsrNext(mLfsr);
          mOp    = (mOp + 1) % 6;
        end else if (mMode == 1) begin
          if (!bistEn) begin
            mMode = 0; mIdleLeft = PERIOD - 1;
          end
        end else if (!bistEn) begin
          mIdleLeft = PERIOD - 1;
        end else if (mIdleLeft == 0) begin
          mMode = 1; mIdleLeft = PERIOD - 1;
        end else begin
          mIdleLeft--;
        end
        if (clrErr) begin
          mErr = 0; mCapValid = 1'b0;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model, mid-cycle.
  always @(negedge clk) begin
    if (chkEn) begin
      bit act;
      act = (mMode == 1) && bistEn && !coreValid;
      check("bist_active", 32'(bistActive), 32'(act));
      check("alu_a",       aluA,            act ? mLfsr : coreA);
      check("alu_b",       aluB,            act ? modelVecB() : coreB);
      check("alu_cont",    32'(aluCont),    32'(act ? opTab[mOp] : coreCont));
      check("tests_done",  32'(testsDone),  mTests);
      check("err_cnt",     32'(errCnt),     mErr);
      check("fault",       32'(fault),      32'(mMode == 2));
      check("fail_a",      failA,           mFailA);
      check("fail_b",      failB,           mFailB);
      check("fail_cont",   32'(failCont),   32'(mFailCont));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitActive(input int maxCyc, output int cyc);
    cyc = 0;
    while (!bistActive && cyc < maxCyc) begin
      tick();
      cyc++;
    end
    if (!bistActive) check("wait_active_timeout", 32'(bistActive), 32'd1);
  endtask

  task automatic applyStimulus(input bit en, input bit cv, input logic [31:0] a);
    bistEn    = en;
    coreValid = cv;
    coreA     = a;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    check(name, act, exp);
  endtask

  initial begin
    int          cyc;
    int          activeSeen;
    logic [2:0]  conts [6];
    logic [2:0]  expConts [6];
    logic [31:0] savedA;
    logic [31:0] savedB;

    expConts = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b110};
    chkEn = 1'b0; rstN = 1'b0; bistEn = 1'b0; clrErr = 1'b0; coreValid = 1'b0;
    coreA = 32'h11111111; coreB = 32'h22222222; coreCont = 3'b010; inject = 1'b0;
    tick(); tick();
    chkEn = 1'b1;
    checkOutput("reset_active",  32'(bistActive), 32'd0);
    checkOutput("reset_alu_a",   aluA,            32'h11111111);
    checkOutput("reset_tests",   32'(testsDone),  32'd0);
    checkOutput("reset_err",     32'(errCnt),     32'd0);

    rstN = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h11111111);
    waitActive(20, cyc);
    checkOutput("first_arm_cycle", cyc, 4);
    checkOutput("vec1_a",    aluA,         32'hACE11234);
    checkOutput("vec1_b",    aluB,         32'h1234ACE1);
    checkOutput("vec1_cont", 32'(aluCont), 32'd0);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        waitActive(20, cyc);
        checkOutput("test_spacing", cyc, 4);
      end
      conts[k] = aluCont;
      if (k == 1) begin
        checkOutput("vec2_a", aluA, 32'h5670891A);
        checkOutput("vec2_b", aluB, 32'h891A5670);
      end
      if (k == 5) begin
        checkOutput("vec6_a", aluA, 32'hE55F0893);
        checkOutput("vec6_b", aluB, 32'hE55F0893);
      end
      tick();
      checkOutput("tests_count", 32'(testsDone), k + 1);
      checkOutput("healthy_err", 32'(errCnt),    32'd0);
    end
    for (int k = 0; k < 6; k++) checkOutput("op_sequence", 32'(conts[k]), 32'(expConts[k]));

    applyStimulus(1'b1, 1'b1, 32'hDEADBEEF);
    activeSeen = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bistActive) activeSeen++;
      checkOutput("core_passthru_a", aluA, 32'hDEADBEEF);
    end
    checkOutput("core_priority", activeSeen, 0);
    applyStimulus(1'b1, 1'b0, 32'hDEADBEEF);
    checkOutput("core_drop_active", 32'(bistActive), 32'd1);
    checkOutput("core_drop_cont",   32'(aluCont),    32'd0);
    tick();
    checkOutput("core_drop_tests",  32'(testsDone),  32'd7);

    inject = 1'b1;
    waitActive(20, cyc);
    checkOutput("inj1_spacing", cyc, 4);
    savedA = mLfsr;
    savedB = modelVecB();
    tick();
    checkOutput("inj1_err",    32'(errCnt),   32'd1);
    checkOutput("inj1_fault",  32'(fault),    32'd0);
    checkOutput("inj1_fail_a", failA,         savedA);
    checkOutput("inj1_fail_b", failB,         savedB);
    checkOutput("inj1_cont",   32'(failCont), 32'b001);
    waitActive(20, cyc);
    tick();
    checkOutput("inj2_fault",  32'(fault),    32'd1);
    checkOutput("inj2_err",    32'(errCnt),   32'd2);
    checkOutput("inj2_fail_a", failA,         savedA);
    activeSeen = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (bistActive) activeSeen++;
    end
    checkOutput("fault_blocks_bist", activeSeen, 0);

    clrErr = 1'b1;
    tick();
    clrErr = 1'b0;
    checkOutput("clr_fault", 32'(fault),  32'd0);
    checkOutput("clr_err",   32'(errCnt), 32'd0);
    waitActive(20, cyc);
    checkOutput("clr_next_test", cyc, 4);
    clrErr = 1'b1;
    tick();
    clrErr = 1'b0;
    checkOutput("clr_wins_err",   32'(errCnt),    32'd0);
    checkOutput("clr_wins_fault", 32'(fault),     32'd0);
    checkOutput("clr_wins_tests", 32'(testsDone), 32'd10);

    inject = 1'b0;
    waitActive(20, cyc);
    applyStimulus(1'b1, 1'b1, 32'h0BADF00D);
    checkOutput("pending_active", 32'(bistActive), 32'd0);
    rstN = 1'b0;
    #1;
    checkOutput("midrst_tests",  32'(testsDone), 32'd0);
    checkOutput("midrst_fail_a", failA,          32'd0);
    checkOutput("midrst_alu_a",  aluA,           32'h0BADF00D);
    checkOutput("midrst_fault",  32'(fault),     32'd0);
    tick();
    rstN = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h0BADF00D);
    waitActive(20, cyc);
    checkOutput("rerun_arm_cycle", cyc, 4);
    checkOutput("rerun_vec_a",     aluA, 32'hACE11234);
    tick(); tick();

    chkEn = 1'b0;
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/alu_bist_sched.md
Name: alu_bist_sched

Overview:
- Shares the 32-bit redundant ALU between the core datapath and a built-in self-test (BIST) engine.
- The core always has priority. BIST vectors go in only on cycles when the core is not using the ALU.
- Each injected vector's result and zero flag are checked against an in-block golden model. Mismatches are counted and the first failing vector is logged.
- Raises a sticky fault once the error limit is reached. Sits between the decode/control logic and the ALU instance.

Parameters:
- PERIOD, 16: idle cycles between BIST arm events; minimum 1.
- ERR_LIMIT, 3: mismatch count that forces the FAULT state; range 1..255.
- LFSR_SEED, 32'hACE11234: LFSR reset value; must be non-zero.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- bist_en  in  1  enables BIST scheduling.
- clr_err  in  1  clears err_cnt and fault.
- core_valid  in  1  core needs the ALU this cycle.
- core_a, core_b  in  32  core operands.
- core_cont  in  3  core alucont.
- alu_a, alu_b  out  32  operands driven to the ALU.
- alu_cont  out  3  alucont driven to the ALU.
- alu_result  in  32  ALU result.
- alu_zero  in  1  ALU zero flag.
- bist_active  out  1  ALU is carrying a BIST vector this cycle.
- tests_done  out  16  number of BIST vectors executed.
- err_cnt  out  8  mismatch count, saturating.
- fault  out  1  sticky fault flag.
- fail_a, fail_b  out  32  operands of the first failing vector.
- fail_cont  out  3  alucont of the first failing vector.

Behaviour:
- Reset (reset=0, immediate):
  - State IDLE, period counter = PERIOD-1, LFSR = LFSR_SEED, op index 0.
  - tests_done, err_cnt, fault, fail_* = 0; capture-valid flag cleared.
  - bist_active = 0, so alu_* = core_*.
- States: IDLE, ARMED, FAULT.
- IDLE:
  - bist_en=1: counter decrements each cycle; at 0, go to ARMED and reload PERIOD-1.
  - bist_en=0: counter held at PERIOD-1.
  - The first arm therefore occurs PERIOD cycles after bist_en rises.
- ARMED:
  - bist_active = (state==ARMED) & ~core_valid & bist_en. This is combinational, zero latency.
  - When bist_active=1:
    - alu_a = lfsr.
    - alu_b = {lfsr[15:0], lfsr[31:16]}, except at op index 5 where alu_b = lfsr.
    - alu_cont = op table entry.
  - When bist_active=0: alu_* = core_* (pure mux).
  - Clock edge with bist_active=1:
    - tests_done+1, wrapping at 16 bits.
    - LFSR advances one Galois step, polynomial 0x80200003.
    - Op index advances modulo 6.
    - Go to IDLE.
  - Mismatch: (alu_result != golden_result) | (alu_zero != golden_zero).
    - err_cnt increments, saturating at 255.
    - If no capture is valid, fail_* capture the vector and the capture flag is set.
    - If the incremented err_cnt >= ERR_LIMIT, go to FAULT instead of IDLE.
  - core_valid=1: stay ARMED with no test. Core traffic is never stalled or delayed.
  - bist_en=0 while ARMED: return to IDLE with no test.
- Op table, indices 0..5:
  - 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 110 SUB with a==b.
  - Index 5 exercises zero=1.
- Golden model:
  - sum = a + (c[2] ? ~b : b) + c[2].
  - SLT result = {31'b0, sum[31]}, with no overflow correction.
  - zero = (result == 0).
- FAULT:
  - fault=1; bist_active is forced to 0; the counter is frozen.
  - Only clr_err leaves FAULT: it goes to IDLE with the counter reloaded.
- clr_err:
  - Next edge: err_cnt=0, fault=0, capture flag cleared.
  - fail_* hold their old values until the next capture.
  - clr_err and a mismatch in the same cycle: clear wins. err_cnt=0 and no FAULT entry, but tests_done, LFSR and the capture still update.
- Reset mid-test: the vector is abandoned and no counters update.

Decomposition:
- Package alu_bist_pkg holds:
  - state encoding (IDLE/ARMED/FAULT);
  - alucont codes AND/OR/ADD/SUB/SLT;
  - the 6-entry op table;
  - LFSR polynomial 32'h80200003.
- One sub-module, alu_golden: combinational reference with inputs a, b, cont and outputs result, zero, implementing the golden-model equations above.
- Scheduler FSM, counters, LFSR and capture registers live in the top module.

Test Plan (PERIOD=4, ERR_LIMIT=2, healthy ALU unless stated):
- Release reset, bist_en=1, core_valid=0:
  - bist_active first high in cycle 4 with alu_a=32'hACE11234 and alu_cont=000.
  - Then high every 5 cycles; tests_done counts 1, 2, 3; err_cnt stays 0.
- Hold core_valid=1 across the arm point:
  - bist_active stays 0 and alu_a==core_a every cycle.
  - Drop core_valid: the test executes in that same cycle.
- Six consecutive tests:
  - alu_cont sequence is 000, 001, 010, 110, 111, 110.
  - The sixth has alu_b==alu_a and the golden zero is 1; no mismatch.
- Bench flips alu_result[0] whenever bist_active=1:
  - After the 1st test: err_cnt=1, fail_a/fail_b/fail_cont equal the first vector.
  - After the 2nd test: fault=1, err_cnt=2, and bist_active stays 0 for 50 cycles.
- From FAULT, pulse clr_err for one cycle:
  - Next cycle: fault=0, err_cnt=0.
  - Next test occurs 4 cycles later. Pulsing clr_err on a mismatch cycle leaves err_cnt=0.
- Assert reset while ARMED and a test is pending:
  - All outputs return to reset values immediately.
  - After release, the first vector again has alu_a=32'hACE11234.
